reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_if.sv | 37 +++
 rtl/reg_file_sb.sv | 79 +++++++
 tb/tb_reg_file_sb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Bus bundle for the scoreboarded register file: two read ports, one write
// port, one issue port and the pending-count readout.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] reg_file_sb_rd1_id;
    logic [ADDR_W-1:0] reg_file_sb_rd2_id;
    logic [DATA_W-1:0] reg_file_sb_rd1_data;
    logic [DATA_W-1:0] reg_file_sb_rd2_data;
    logic              reg_file_sb_rd1_busy;
    logic              reg_file_sb_rd2_busy;
    logic              reg_file_sb_wr_en;
    logic [ADDR_W-1:0] reg_file_sb_wr_id;
    logic [DATA_W-1:0] reg_file_sb_wr_data;
    logic              reg_file_sb_iss_en;
    logic [ADDR_W-1:0] reg_file_sb_iss_id;
    logic [ADDR_W:0]   reg_file_sb_pend_cnt;

    modport master (
        output reg_file_sb_rd1_id, reg_file_sb_rd2_id,
        output reg_file_sb_wr_en, reg_file_sb_wr_id, reg_file_sb_wr_data,
        output reg_file_sb_iss_en, reg_file_sb_iss_id,
        input  reg_file_sb_rd1_data, reg_file_sb_rd2_data,
        input  reg_file_sb_rd1_busy, reg_file_sb_rd2_busy,
        input  reg_file_sb_pend_cnt
    );

    modport slave (
        input  reg_file_sb_rd1_id, reg_file_sb_rd2_id,
        input  reg_file_sb_wr_en, reg_file_sb_wr_id, reg_file_sb_wr_data,
        input  reg_file_sb_iss_en, reg_file_sb_iss_id,
        output reg_file_sb_rd1_data, reg_file_sb_rd2_data,
        output reg_file_sb_rd1_busy, reg_file_sb_rd2_busy,
        output reg_file_sb_pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-through bypass and a per-register pending
// scoreboard; pend_cnt tracks how many destinations await a write.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic         reg_file_sb_clk,
    input  logic         reg_file_sb_rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic wr_ok, iss_ok, cnt_inc, cnt_dec;
    logic rd1_hit, rd2_hit;

    function automatic logic is_zero_idx(input logic [ADDR_W-1:0] id);
        return (ZERO_REG != 0) && (id == '0);
    endfunction

    assign wr_ok  = bus.reg_file_sb_wr_en  && !is_zero_idx(bus.reg_file_sb_wr_id);
    assign iss_ok = bus.reg_file_sb_iss_en && !is_zero_idx(bus.reg_file_sb_iss_id);

    // An issue to the index being written re-arms it, so the write never clears it.
    always_comb begin
        pend_d  = pend_q;
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (wr_ok) begin
            pend_d[bus.reg_file_sb_wr_id] = 1'b0;
            cnt_dec = pend_q[bus.reg_file_sb_wr_id] &&
                      !(iss_ok && (bus.reg_file_sb_iss_id == bus.reg_file_sb_wr_id));
        end
        if (iss_ok) begin
            pend_d[bus.reg_file_sb_iss_id] = 1'b1;
            cnt_inc = !pend_q[bus.reg_file_sb_iss_id];
        end
        cnt_d = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge reg_file_sb_clk) begin
        if (reg_file_sb_rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) regs_q[bus.reg_file_sb_wr_id] <= bus.reg_file_sb_wr_data;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rd1_hit = wr_ok && (bus.reg_file_sb_wr_id == bus.reg_file_sb_rd1_id);
    assign rd2_hit = wr_ok && (bus.reg_file_sb_wr_id == bus.reg_file_sb_rd2_id);

    // Outputs are forced quiet while reset is held, before the edge clears state.
    assign bus.reg_file_sb_rd1_data =
        (reg_file_sb_rst || is_zero_idx(bus.reg_file_sb_rd1_id)) ? '0 :
        rd1_hit ? bus.reg_file_sb_wr_data : regs_q[bus.reg_file_sb_rd1_id];
    assign bus.reg_file_sb_rd2_data =
        (reg_file_sb_rst || is_zero_idx(bus.reg_file_sb_rd2_id)) ? '0 :
        rd2_hit ? bus.reg_file_sb_wr_data : regs_q[bus.reg_file_sb_rd2_id];

    assign bus.reg_file_sb_rd1_busy =
        !reg_file_sb_rst && pend_q[bus.reg_file_sb_rd1_id] && !rd1_hit;
    assign bus.reg_file_sb_rd2_busy =
        !reg_file_sb_rst && pend_q[bus.reg_file_sb_rd2_id] && !rd2_hit;

    assign bus.reg_file_sb_pend_cnt = reg_file_sb_rst ? '0 : cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, zero register, bypass, scoreboard,
// collisions, full count and reset mid-operation.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .reg_file_sb_clk (clk),
        .reg_file_sb_rst (rst),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_file_sb_wr_en   = 1'b0;
        bus.reg_file_sb_wr_id   = '0;
        bus.reg_file_sb_wr_data = '0;
        bus.reg_file_sb_iss_en  = 1'b0;
        bus.reg_file_sb_iss_id  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.reg_file_sb_rd1_id = 5'd3;
        bus.reg_file_sb_rd2_id = 5'd31;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd3; bus.reg_file_sb_wr_data = 32'hDEAD;
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd31;
        tick(); tick();
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h0) begin errors++; $display("FAIL rst_hold_rd1 got %0h exp 0", bus.reg_file_sb_rd1_data); end
        checks++; if (bus.reg_file_sb_rd2_busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy2 got %0b exp 0", bus.reg_file_sb_rd2_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL rst_hold_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
        idle();
        rst = 1'b0;
        #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h0) begin errors++; $display("FAIL rst_rd1_data got %0h exp 0", bus.reg_file_sb_rd1_data); end
        checks++; if (bus.reg_file_sb_rd2_data !== 32'h0) begin errors++; $display("FAIL rst_rd2_data got %0h exp 0", bus.reg_file_sb_rd2_data); end
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0 || bus.reg_file_sb_rd2_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b%0b exp 00", bus.reg_file_sb_rd1_busy, bus.reg_file_sb_rd2_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
    endtask

    task automatic test_zero_reg();
        bus.reg_file_sb_rd1_id = 5'd0;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd0; bus.reg_file_sb_wr_data = 32'h1234;
        #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h0) begin errors++; $display("FAIL zero_nobypass got %0h exp 0", bus.reg_file_sb_rd1_data); end
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h0) begin errors++; $display("FAIL zero_read got %0h exp 0", bus.reg_file_sb_rd1_data); end
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd0;
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL zero_issue_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0) begin errors++; $display("FAIL zero_issue_busy got %0b exp 0", bus.reg_file_sb_rd1_busy); end
    endtask

    task automatic test_bypass();
        bus.reg_file_sb_rd1_id = 5'd1;
        bus.reg_file_sb_rd2_id = 5'd2;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd1; bus.reg_file_sb_wr_data = 32'd4231;
        #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'd4231) begin errors++; $display("FAIL bypass_same_cycle got %0d exp 4231", bus.reg_file_sb_rd1_data); end
        checks++; if (bus.reg_file_sb_rd2_data !== 32'd0) begin errors++; $display("FAIL bypass_other_port got %0d exp 0", bus.reg_file_sb_rd2_data); end
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'd4231) begin errors++; $display("FAIL bypass_stored got %0d exp 4231", bus.reg_file_sb_rd1_data); end
    endtask

    task automatic test_scoreboard();
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd5;
        tick(); idle();
        bus.reg_file_sb_rd1_id = 5'd5;
        #1;
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %0b exp 1", bus.reg_file_sb_rd1_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_cnt_set got %0d exp 1", bus.reg_file_sb_pend_cnt); end
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd5; bus.reg_file_sb_wr_data = 32'h55;
        #1;
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_bypass got %0b exp 0", bus.reg_file_sb_rd1_busy); end
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h55) begin errors++; $display("FAIL sb_data_bypass got %0h exp 55", bus.reg_file_sb_rd1_data); end
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0) begin errors++; $display("FAIL sb_busy_clr got %0b exp 0", bus.reg_file_sb_rd1_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_cnt_clr got %0d exp 0", bus.reg_file_sb_pend_cnt); end
    endtask

    task automatic test_redundant();
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd6;
        tick(); tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL dup_issue_cnt got %0d exp 1", bus.reg_file_sb_pend_cnt); end
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd9; bus.reg_file_sb_wr_data = 32'h99;
        tick(); idle();
        bus.reg_file_sb_rd1_id = 5'd9; bus.reg_file_sb_rd2_id = 5'd6;
        #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL idle_write_cnt got %0d exp 1", bus.reg_file_sb_pend_cnt); end
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h99) begin errors++; $display("FAIL idle_write_data got %0h exp 99", bus.reg_file_sb_rd1_data); end
        checks++; if (bus.reg_file_sb_rd2_busy !== 1'b1) begin errors++; $display("FAIL dup_issue_busy got %0b exp 1", bus.reg_file_sb_rd2_busy); end
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd6; bus.reg_file_sb_wr_data = 32'h66;
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL dup_clear_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
    endtask

    task automatic test_collision();
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd7;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd7; bus.reg_file_sb_wr_data = 32'h77;
        tick(); idle();
        bus.reg_file_sb_rd1_id = 5'd7; bus.reg_file_sb_rd2_id = 5'd8;
        #1;
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b1) begin errors++; $display("FAIL coll_same_busy got %0b exp 1", bus.reg_file_sb_rd1_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL coll_same_cnt got %0d exp 1", bus.reg_file_sb_pend_cnt); end
        checks++; if (bus.reg_file_sb_rd1_data !== 32'h77) begin errors++; $display("FAIL coll_same_data got %0h exp 77", bus.reg_file_sb_rd1_data); end
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd8;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd7; bus.reg_file_sb_wr_data = 32'h70;
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0) begin errors++; $display("FAIL coll_diff_busy7 got %0b exp 0", bus.reg_file_sb_rd1_busy); end
        checks++; if (bus.reg_file_sb_rd2_busy !== 1'b1) begin errors++; $display("FAIL coll_diff_busy8 got %0b exp 1", bus.reg_file_sb_rd2_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL coll_diff_cnt got %0d exp 1", bus.reg_file_sb_pend_cnt); end
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd8; bus.reg_file_sb_wr_data = 32'h88;
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL coll_drain_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
    endtask

    task automatic test_full_and_reset();
        for (int i = 1; i < 32; i++) begin
            bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'(i);
            tick();
        end
        idle();
        bus.reg_file_sb_rd1_id = 5'd31; bus.reg_file_sb_rd2_id = 5'd1;
        #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd31) begin errors++; $display("FAIL full_cnt got %0d exp 31", bus.reg_file_sb_pend_cnt); end
        checks++; if (bus.reg_file_sb_rd1_busy !== 1'b1 || bus.reg_file_sb_rd2_busy !== 1'b1) begin errors++; $display("FAIL full_busy got %0b%0b exp 11", bus.reg_file_sb_rd1_busy, bus.reg_file_sb_rd2_busy); end
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd12;
        tick(); idle(); #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd31) begin errors++; $display("FAIL full_reissue_cnt got %0d exp 31", bus.reg_file_sb_pend_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL midrst_hold_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", bus.reg_file_sb_pend_cnt); end
        for (int i = 0; i < 32; i++) begin
            bus.reg_file_sb_rd1_id = 5'(i);
            bus.reg_file_sb_rd2_id = 5'(31 - i);
            #1;
            checks++; if (bus.reg_file_sb_rd1_data !== 32'h0 || bus.reg_file_sb_rd2_data !== 32'h0) begin errors++; $display("FAIL midrst_data[%0d] got %0h/%0h exp 0/0", i, bus.reg_file_sb_rd1_data, bus.reg_file_sb_rd2_data); end
            checks++; if (bus.reg_file_sb_rd1_busy !== 1'b0 || bus.reg_file_sb_rd2_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy[%0d] got %0b%0b exp 00", i, bus.reg_file_sb_rd1_busy, bus.reg_file_sb_rd2_busy); end
        end
    endtask

    task automatic test_release();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        bus.reg_file_sb_wr_en = 1'b1; bus.reg_file_sb_wr_id = 5'd3; bus.reg_file_sb_wr_data = 32'hAB;
        bus.reg_file_sb_iss_en = 1'b1; bus.reg_file_sb_iss_id = 5'd4;
        tick(); idle();
        bus.reg_file_sb_rd1_id = 5'd3; bus.reg_file_sb_rd2_id = 5'd4;
        #1;
        checks++; if (bus.reg_file_sb_rd1_data !== 32'hAB) begin errors++; $display("FAIL release_write got %0h exp ab", bus.reg_file_sb_rd1_data); end
        checks++; if (bus.reg_file_sb_rd2_busy !== 1'b1) begin errors++; $display("FAIL release_issue got %0b exp 1", bus.reg_file_sb_rd2_busy); end
        checks++; if (bus.reg_file_sb_pend_cnt !== 6'd1) begin errors++; $display("FAIL release_cnt got %0d exp 1", bus.reg_file_sb_pend_cnt); end
    endtask

    initial begin
        idle();
        bus.reg_file_sb_rd1_id = '0;
        bus.reg_file_sb_rd2_id = '0;
        test_reset();
        test_zero_reg();
        test_bypass();
        test_scoreboard();
        test_redundant();
        test_collision();
        test_full_and_reset();
        test_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
